decode_stage: RTL
=================

# decode_stage

Registered instruction-decode stage between fetch and execute in the pipelined datapath. It classifies the 8-bit primary opcode into register-file, memory and writeback control bundles and holds them in a one-entry pipeline register with valid/ready handshakes. It also tracks in-flight returns with a drain counter, latches illegal-opcode and halt conditions in a small state machine, and is parametrised in instruction width and writeback-select width.

## Interface
- INSTR_W, 32, instruction width in bits; minimum 16.
- SEL_W, 4, width of the ex_mem and mem_wb data-select fields.
- RET_DRAIN, 3, number of cycles fetch is held after a return is accepted; range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_instr  in  INSTR_W  instruction from fetch.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- flush  in  1  discard the held and incoming instruction.
- out_valid  out  1  the decoded bundle is valid.
- out_ready  in  1  execute accepts the bundle.
- reg_file_ren  out  2  read enables, with bit0 for port A and bit1 for port B.
- reg_file_wen  out  2  write enables.
- main_memory_enable, frame_buffer_enable, call_stack_enable  out  1 each  memory target selects.
- mem_wren  out  2  memory write enables.
- ex_mem_data_input_sel, mem_wb_data_input_sel  out  SEL_W each  data-path selects.
- out_instr  out  INSTR_W  the instruction passed through to execute.
- return_in_pipeline  out  1  a return is draining.
- fetch_stall  out  1  fetch must not present new instructions.
- illegal_opcode_exception  out  1  sticky exception flag.
- halted  out  1  the stage is in the HALTED state.

## Operation
- The opcode is in_instr[7:0]. For memory-class opcodes, the sub-op is in_instr[9:8], with 00 selecting main memory, 01 the frame buffer and 10 the call stack. Sub-op 11 is illegal.
- Decode table, listed as opcode: ren, wen, mem_wren, ex_sel, wb_sel:
  - 00 NOP: 00, 00, 00, 0, 0.
  - BC, 9E, 9B, A5: 01, 01, 00, 1, 1.
  - 80, 8E, 97: 11, 01, 00, 1, 1.
  - FB load/pop: 01, 01, 00, 2, 2, plus a memory enable chosen by the sub-op.
  - C4 store/push: 11, 00, 01, 2, 0, plus a memory enable chosen by the sub-op.
  - F8 load immediate: 00, 01, 00, 3, 3.
  - 9C mov/in/out: 01, 01, 00, 4, 4.
  - F9 program-memory load: 01, 01, 00, 5, 5.
  - 38 branch: 01, 00, 00, 6, 0.
  - 42 call: 00, 00, 01, 7, 0, with call_stack_enable=1.
  - 43 return/reti: 00, 00, 00, 7, 0, with call_stack_enable=1.
  - 1F halt: all zeros.
- Any other opcode, or a memory sub-op of 11, is illegal. An illegal opcode produces a NOP bundle, so every control signal is 0.
- State machine:
  - RUN → EXCEPT when an illegal instruction is accepted.
  - RUN → HALTED when opcode 1F is accepted.
  - EXCEPT and HALTED are left only by reset.
  - In EXCEPT and HALTED, in_ready=0 and no new bundle is loaded. A bundle already held still drains normally.
- Return drain:
  - Accepting opcode 43 loads the counter with RET_DRAIN.
  - The counter decrements each cycle while it is nonzero.
  - return_in_pipeline = (count≠0).
  - fetch_stall = return_in_pipeline | halted | illegal_opcode_exception.
  - The stage ignores in_valid while the counter is nonzero, because in_ready=0.
- in_ready = state==RUN & count==0 & (!out_valid | out_ready).
- Flush:
  - out_valid goes to 0 on the next edge.
  - An instruction offered in the same cycle is not accepted.
  - The return counter is cleared.
  - flush does not clear the EXCEPT or HALTED state.
- Reset values:
  - All outputs are 0, and all select fields are 0.
  - State is RUN, the counter is 0 and out_instr is 0.
  - After reset, in_ready=1 on the first cycle.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N appears with out_valid=1 after edge N.
- Throughput is one instruction per cycle when out_ready is held at 1 and no return is draining.
- The bundle and out_instr hold stable while out_valid=1 and out_ready=0.
- On a simultaneous accept and drain (out_valid & out_ready & in_valid & in_ready), the new bundle replaces the old one on the same edge.
- After a return is accepted at edge N, in_ready is 0 for RET_DRAIN cycles and returns to 1 once the counter reaches 0.
- illegal_opcode_exception and halted assert on the accepting edge, together with out_valid for that NOP bundle.
- Priority on the same edge is rst > flush > accept.
- A reset mid-drain or mid-exception returns the stage to the full reset state within one edge.

## Test plan
- Reset, then stream 80, BC and F8 with out_ready=1. Required: three consecutive out_valid cycles with ren 11, 01, 00 and wen 01 on each, each appearing one cycle after acceptance.
- Send C4 with sub-op 01, then FB with sub-op 10. Required: C4 gives frame_buffer_enable=1, mem_wren=01, ren=11. FB gives call_stack_enable=1, wen=01.
- Send 43 with RET_DRAIN=3. Required:
  - return_in_pipeline and fetch_stall are high for exactly 3 cycles.
  - in_ready=0 for those 3 cycles.
  - The next instruction is accepted on the 4th cycle.
- Send opcode 5A, then a mid-stream reset. Required:
  - 5A yields a NOP bundle with out_valid=1 and illegal_opcode_exception=1.
  - in_ready stays 0 until rst.
  - All outputs are 0 after rst.
- Hold out_ready=0 with 97 held in the stage, then assert flush together with a new in_valid. Required: 97 stays stable while out_ready=0. After flush, out_valid=0 and the new instruction is not accepted.
- Send 1F followed by 80. Required: halted=1 and fetch_stall=1, and 80 is never accepted.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/execute handshake and decoded control bundle
// exchanged with the decode stage.
interface decode_stage_if #(
  parameter int INSTR_W = 32,
  parameter int SEL_W   = 4
);
  logic [INSTR_W-1:0] in_instr;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         reg_file_ren;
  logic [1:0]         reg_file_wen;
  logic               main_memory_enable;
  logic               frame_buffer_enable;
  logic               call_stack_enable;
  logic [1:0]         mem_wren;
  logic [SEL_W-1:0]   ex_mem_data_input_sel;
  logic [SEL_W-1:0]   mem_wb_data_input_sel;
  logic [INSTR_W-1:0] out_instr;
  logic               return_in_pipeline;
  logic               fetch_stall;
  logic               illegal_opcode_exception;
  logic               halted;

  modport master (
    output in_instr, in_valid, flush, out_ready,
    input  in_ready, out_valid,
    input  reg_file_ren, reg_file_wen,
    input  main_memory_enable, frame_buffer_enable,
    input  call_stack_enable, mem_wren,
    input  ex_mem_data_input_sel, mem_wb_data_input_sel,
    input  out_instr, return_in_pipeline, fetch_stall,
    input  illegal_opcode_exception, halted
  );

  modport slave (
    input  in_instr, in_valid, flush, out_ready,
    output in_ready, out_valid,
    output reg_file_ren, reg_file_wen,
    output main_memory_enable, frame_buffer_enable,
    output call_stack_enable, mem_wren,
    output ex_mem_data_input_sel, mem_wb_data_input_sel,
    output out_instr, return_in_pipeline, fetch_stall,
    output illegal_opcode_exception, halted
  );
endinterface

// File: rtl/decode_stage.sv
// Opcode decode into a one-entry control register, with
// return-drain counter and sticky exception/halt FSM.
module decode_stage #(
  parameter int INSTR_W   = 32,
  parameter int SEL_W     = 4,
  parameter int RET_DRAIN = 3
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXCEPT = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]       ren;
    logic [1:0]       wen;
    logic [1:0]       mwr;
    logic             mm;
    logic             fb;
    logic             cs;
    logic [SEL_W-1:0] ex;
    logic [SEL_W-1:0] wb;
  } ctl_t;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               val_q, val_d;
  ctl_t               ctl_q, ctl_d;
  logic [INSTR_W-1:0] ins_q, ins_d;

  logic [7:0] op;
  logic [1:0] sub;
  ctl_t       dec;
  logic       dec_ill;
  logic       dec_halt;
  logic       dec_ret;
  logic       in_ready;
  logic       accept;

  logic is_nop, is_a1, is_a2, is_ld, is_st;
  logic is_li, is_mov, is_pml, is_br;
  logic is_call, is_ret, is_hlt;

  assign op  = bus.in_instr[7:0];
  assign sub = bus.in_instr[9:8];

  assign is_nop  = op == 8'h00;
  assign is_a1   = op inside {8'hBC, 8'h9E, 8'h9B, 8'hA5};
  assign is_a2   = op inside {8'h80, 8'h8E, 8'h97};
  assign is_ld   = op == 8'hFB;
  assign is_st   = op == 8'hC4;
  assign is_li   = op == 8'hF8;
  assign is_mov  = op == 8'h9C;
  assign is_pml  = op == 8'hF9;
  assign is_br   = op == 8'h38;
  assign is_call = op == 8'h42;
  assign is_ret  = op == 8'h43;
  assign is_hlt  = op == 8'h1F;

  // Opcode classification; illegal encodings leave a NOP bundle
  always_comb begin
    dec      = '0;
    dec_ill  = 1'b0;
    dec_halt = 1'b0;
    dec_ret  = 1'b0;
    unique case (1'b1)
      is_nop: ;
      is_a1: begin
        dec.ren = 2'b01;
        dec.wen = 2'b01;
        dec.ex  = SEL_W'(1);
        dec.wb  = SEL_W'(1);
      end
      is_a2: begin
        dec.ren = 2'b11;
        dec.wen = 2'b01;
        dec.ex  = SEL_W'(1);
        dec.wb  = SEL_W'(1);
      end
      is_ld: begin
        if (sub == 2'b11) begin
          dec_ill = 1'b1;
        end else begin
          dec.ren = 2'b01;
          dec.wen = 2'b01;
          dec.ex  = SEL_W'(2);
          dec.wb  = SEL_W'(2);
          dec.mm  = sub == 2'b00;
          dec.fb  = sub == 2'b01;
          dec.cs  = sub == 2'b10;
        end
      end
      is_st: begin
        if (sub == 2'b11) begin
          dec_ill = 1'b1;
        end else begin
          dec.ren = 2'b11;
          dec.mwr = 2'b01;
          dec.ex  = SEL_W'(2);
          dec.mm  = sub == 2'b00;
          dec.fb  = sub == 2'b01;
          dec.cs  = sub == 2'b10;
        end
      end
      is_li: begin
        dec.wen = 2'b01;
        dec.ex  = SEL_W'(3);
        dec.wb  = SEL_W'(3);
      end
      is_mov: begin
        dec.ren = 2'b01;
        dec.wen = 2'b01;
        dec.ex  = SEL_W'(4);
        dec.wb  = SEL_W'(4);
      end
      is_pml: begin
        dec.ren = 2'b01;
        dec.wen = 2'b01;
        dec.ex  = SEL_W'(5);
        dec.wb  = SEL_W'(5);
      end
      is_br: begin
        dec.ren = 2'b01;
        dec.ex  = SEL_W'(6);
      end
      is_call: begin
        dec.mwr = 2'b01;
        dec.ex  = SEL_W'(7);
        dec.cs  = 1'b1;
      end
      is_ret: begin
        dec.ex  = SEL_W'(7);
        dec.cs  = 1'b1;
        dec_ret = 1'b1;
      end
      is_hlt: dec_halt = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready = (state_q == RUN) && (cnt_q == 4'd0)
                 && (!val_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Sticky exception/halt transitions on an accepted opcode
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && accept) begin
      if (dec_ill)       state_d = EXCEPT;
      else if (dec_halt) state_d = HALTED;
    end
  end

  // Next pipeline register contents and drain count
  always_comb begin
    val_d = val_q;
    ctl_d = ctl_q;
    ins_d = ins_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      val_d = 1'b0;
      cnt_d = 4'd0;
    end else begin
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      if (accept) begin
        val_d = 1'b1;
        ctl_d = dec;
        ins_d = bus.in_instr;
        if (dec_ret) cnt_d = 4'(RET_DRAIN);
      end else if (val_q && bus.out_ready) begin
        val_d = 1'b0;
      end
    end
  end

  // State, counter and bundle registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      val_q   <= 1'b0;
      ctl_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ctl_q   <= ctl_d;
      ins_q   <= ins_d;
    end
  end

  assign bus.in_ready                 = in_ready;
  assign bus.out_valid                = val_q;
  assign bus.reg_file_ren             = ctl_q.ren;
  assign bus.reg_file_wen             = ctl_q.wen;
  assign bus.mem_wren                 = ctl_q.mwr;
  assign bus.main_memory_enable       = ctl_q.mm;
  assign bus.frame_buffer_enable      = ctl_q.fb;
  assign bus.call_stack_enable        = ctl_q.cs;
  assign bus.ex_mem_data_input_sel    = ctl_q.ex;
  assign bus.mem_wb_data_input_sel    = ctl_q.wb;
  assign bus.out_instr                = ins_q;
  assign bus.return_in_pipeline       = cnt_q != 4'd0;
  assign bus.illegal_opcode_exception = state_q == EXCEPT;
  assign bus.halted                   = state_q == HALTED;
  assign bus.fetch_stall              = (cnt_q != 4'd0)
                                     || (state_q != RUN);

endmodule
